lfsr_draw_arbiter: RTL and testbench
====================================

Name: lfsr_draw_arbiter

Overview:
- Shared random-number source for the design: owns one 8-bit Fibonacci LFSR and serves single-byte "draws" to NUM_REQ requesters in round-robin order.
- Sequences the LFSR. It handles seed load (with zero-seed protection), then a warm-up phase that discards WARMUP states, then a serve phase.
- In the serve phase the LFSR advances only when a value is handed out, so no value is skipped or given to two requesters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WARMUP, 8, LFSR steps discarded after reset or reseed before serving (0..255; 0 = serve immediately)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- seed_load  in  1  load seed this cycle
- seed  in  8  seed value; 0x00 loads 0x01
- req  in  NUM_REQ  level request per requester
- gnt  out  NUM_REQ  one-hot grant, registered, one cycle per draw
- rnd_valid  out  1  equals |gnt
- rnd_data  out  8  drawn byte, valid while rnd_valid
- busy  out  1  high during WARMUP state

Behaviour:
- LFSR step: next = {s[6:0], s[7]^s[5]^s[4]^s[1]}. This is maximal length, period 255, and never reaches 0x00.
- Reset values: lfsr = 0x01, rr pointer = NUM_REQ-1 (so req[0] wins first), gnt = 0, rnd_valid = 0, rnd_data = 0x00, warm counter = WARMUP, state = WARMUP (SERVE if WARMUP==0), busy = (WARMUP!=0).
- WARMUP state:
  - every cycle lfsr <= next and cnt <= cnt-1;
  - when cnt reaches 1 the state becomes SERVE at that edge;
  - req is ignored; gnt = 0.
- SERVE state, at each edge with any req sampled high:
  - winner = first set bit searching upward from pointer+1, with wrap-around;
  - gnt <= onehot(winner), rnd_data <= lfsr, lfsr <= next, pointer <= winner.
- SERVE state, with no req: gnt <= 0, lfsr holds, rnd_data holds its last value.
- Latency and throughput: gnt appears one cycle after req is sampled. Back-to-back draws are allowed, one per cycle.
- req is a level signal. Every edge on which req[i] is high and i wins produces one draw. A requester that wants exactly one draw drops req in the cycle it sees gnt[i].
- seed_load is accepted in any state:
  - lfsr <= (seed==0 ? 0x01 : seed), cnt <= WARMUP, state <= WARMUP (SERVE if WARMUP==0), gnt <= 0;
  - the rr pointer is unchanged.
- Simultaneous seed_load and req: seed_load wins; no grant and no draw that cycle.
- seed_load during WARMUP restarts the warm-up count from WARMUP using the new seed.
- rst has priority over everything and returns all state to the reset values, including mid-warm-up and mid-burst.
- With WARMUP==0, a seed load makes the very next draw return the loaded value itself.

Decomposition:
- Package lfsr_pkg holds:
  - LFSR_W = 8
  - LFSR_RESET = 8'h01
  - tap mask 8'hB2
  - function lfsr_next(s)
  - enum state_t {ST_WARMUP, ST_SERVE}
- Sub-module rr_arbiter (NUM_REQ):
  - ports req, pointer, advance; outputs winner index and onehot;
  - purely combinational, with the pointer register kept in the parent.

Test Plan:
- Reset, WARMUP=8:
  - busy high for exactly 8 cycles after rst drops, then low;
  - hold req=0001 for 2 cycles, then drop; the two gnt=0001 cycles return rnd_data 0x58 then 0xB1.
- Round-robin after reset: hold req=1111 for 5 cycles; gnt = 0001, 0010, 0100, 1000, 0001 with rnd_data 0x58, 0xB1, 0x63, 0xC6, 0x8C.
- Seed 0xAB:
  - pulse seed_load once; busy for 8 cycles, with req ignored meanwhile (gnt=0);
  - the first draw returns 0xB5;
  - repeat with WARMUP=0: the first draw returns 0xAB, the second 0x57.
- Zero seed: seed_load with seed=0x00 gives the first draw 0x58 (as after reset). Over 255 consecutive draws, rnd_data is never 0x00 and the 256th equals the 1st.
- Collisions and interruptions:
  - seed_load together with req=0100 produces no grant that cycle;
  - seed_load asserted again at warm-up cycle 4 restarts the 8-cycle busy window;
  - rst asserted mid-burst gives gnt=0 next cycle, and the next draws start from 0x58 with req[0] first.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: 8-bit Fibonacci register, taps 7/5/4/1 (period 255).
// Pure declarations; no latency or flow control.
package lfsr_pkg;

  localparam int                LFSR_W     = 8;
  localparam logic [LFSR_W-1:0] LFSR_RESET = 8'h01;
  localparam logic [LFSR_W-1:0] LFSR_TAPS  = 8'hB2;

  typedef enum logic {
    ST_WARMUP,
    ST_SERVE
  } state_t;

  // Shift left, feed back the XOR of the tapped bits into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req above pointer, wrapping.
// Zero latency; onehot is all-zero unless advance is high and some req is set.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] pointer,
  input  logic                       advance,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic [NUM_REQ-1:0]         onehot
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'((int'(pointer) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    onehot = '0;
    if (advance && found) begin
      onehot[winner] = 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_draw_arbiter.sv
// Shared random byte source: seeds and warms an 8-bit LFSR, then hands one byte per
// cycle to round-robin requesters; grant registered one cycle after req, LFSR steps only on a draw.
module lfsr_draw_arbiter
  import lfsr_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WARMUP  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rnd_valid,
  output logic [LFSR_W-1:0]  rnd_data,
  output logic               busy
);

  localparam int         IDX_W     = $clog2(NUM_REQ);
  localparam logic [7:0] WARM_INIT = 8'(WARMUP);
  localparam state_t     ST_INIT   = (WARMUP == 0) ? ST_SERVE : ST_WARMUP;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [LFSR_W-1:0]   rnd_data_q, rnd_data_d;

  logic                draw;
  logic [IDX_W-1:0]    arb_winner;
  logic [NUM_REQ-1:0]  arb_onehot;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req     (req),
    .pointer (ptr_q),
    .advance (draw),
    .winner  (arb_winner),
    .onehot  (arb_onehot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      lfsr_q     <= LFSR_RESET;
      cnt_q      <= WARM_INIT;
      ptr_q      <= IDX_W'(NUM_REQ - 1);
      gnt_q      <= '0;
      rnd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      rnd_data_q <= rnd_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (seed_load) begin
      state_d = ST_INIT;
    end else if (state_q == ST_WARMUP && cnt_q <= 8'd1) begin
      state_d = ST_SERVE;
    end
  end

  // A seed load pre-empts any draw in the same cycle.
  always_comb begin
    draw       = (state_q == ST_SERVE) && (|req) && !seed_load;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    gnt_d      = arb_onehot;
    rnd_data_d = rnd_data_q;
    if (seed_load) begin
      lfsr_d = (seed == '0) ? LFSR_RESET : seed;
      cnt_d  = WARM_INIT;
    end else if (state_q == ST_WARMUP) begin
      lfsr_d = lfsr_next(lfsr_q);
      cnt_d  = cnt_q - 8'd1;
    end else if (draw) begin
      lfsr_d     = lfsr_next(lfsr_q);
      ptr_d      = arb_winner;
      rnd_data_d = lfsr_q;
    end
  end

  always_comb begin
    busy      = (state_q == ST_WARMUP);
    gnt       = gnt_q;
    rnd_valid = |gnt_q;
    rnd_data  = rnd_data_q;
  end

endmodule

// File: tb/tb_lfsr_draw_arbiter.sv
// Scoreboard bench: expected grants/bytes queued as req is driven, popped on rnd_valid.
// Instance a uses WARMUP=8, instance b uses WARMUP=0.
module tb_lfsr_draw_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0] g;
    logic [7:0]   d;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         a_seed_load, b_seed_load;
  logic [7:0]   a_seed, b_seed;
  logic [N-1:0] a_req, b_req;
  logic [N-1:0] a_gnt, b_gnt;
  logic         a_vld, b_vld;
  logic [7:0]   a_data, b_data;
  logic         a_busy, b_busy;

  lfsr_draw_arbiter #(.NUM_REQ(N), .WARMUP(8)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .seed_load (a_seed_load),
    .seed      (a_seed),
    .req       (a_req),
    .gnt       (a_gnt),
    .rnd_valid (a_vld),
    .rnd_data  (a_data),
    .busy      (a_busy)
  );

  lfsr_draw_arbiter #(.NUM_REQ(N), .WARMUP(0)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .seed_load (b_seed_load),
    .seed      (b_seed),
    .req       (b_req),
    .gnt       (b_gnt),
    .rnd_valid (b_vld),
    .rnd_data  (b_data),
    .busy      (b_busy)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  exp_t       q_a[$];
  exp_t       q_b[$];
  logic [7:0] seen[$];
  bit         rec  = 1'b0;
  bit         done = 1'b0;
  logic [7:0] m_lfsr;
  int         m_ptr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[1]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [N-1:0] g, input logic [7:0] d);
    q_a.push_back(exp_t'{g, d});
  endtask

  task automatic push_b(input logic [N-1:0] g, input logic [7:0] d);
    q_b.push_back(exp_t'{g, d});
  endtask

  // Counts edges until busy drops (bounded); optionally requires gnt=0 throughout.
  task automatic wait_busy(input string tag, input int exp_len, input bit chk_gnt);
    int c = 0;
    while (a_busy && c < 40) begin
      cyc();
      c++;
      if (chk_gnt) chk({tag, "_gnt"}, a_gnt, 0);
    end
    chk(tag, c, exp_len);
  endtask

  // Holds req for n edges, queueing the model's expected winner and byte per edge.
  task automatic model_draws(input logic [N-1:0] r, input int n, input bit keep);
    a_req = r;
    for (int k = 0; k < n; k++) begin
      int   w = -1;
      exp_t e;
      for (int i = 1; i <= N; i++) begin
        if (w < 0 && r[(m_ptr + i) % N]) w = (m_ptr + i) % N;
      end
      e.g    = '0;
      e.g[w] = 1'b1;
      e.d    = m_lfsr;
      q_a.push_back(e);
      m_ptr  = w;
      m_lfsr = step(m_lfsr);
      cyc();
    end
    if (!keep) a_req = '0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!done) begin
      if (a_vld) begin
        if (q_a.size() == 0) begin
          chk("a_unexpected_draw", a_gnt, 0);
        end else begin
          e = q_a.pop_front();
          chk("a_gnt", a_gnt, e.g);
          chk("a_data", a_data, e.d);
        end
        if (rec) seen.push_back(a_data);
      end
      if (b_vld) begin
        if (q_b.size() == 0) begin
          chk("b_unexpected_draw", b_gnt, 0);
        end else begin
          e = q_b.pop_front();
          chk("b_gnt", b_gnt, e.g);
          chk("b_data", b_data, e.d);
        end
      end
    end
  end

  initial begin
    int zeros;
    rst = 1'b1;
    a_seed_load = 1'b0; a_seed = '0; a_req = '0;
    b_seed_load = 1'b0; b_seed = '0; b_req = '0;
    cyc();
    cyc();
    chk("rst_gnt", a_gnt, 0);
    chk("rst_vld", a_vld, 0);
    chk("rst_data", a_data, 0);
    chk("rst_busy", a_busy, 1);
    chk("b_rst_busy", b_busy, 0);
    rst = 1'b0;

    wait_busy("busy_after_rst", 8, 1'b0);
    push_a(4'b0001, 8'h58);
    push_a(4'b0001, 8'hB1);
    a_req = 4'b0001;
    cyc(); cyc();
    a_req = '0;
    cyc(); cyc();
    chk("drain_first", q_a.size(), 0);

    // WARMUP=0: the loaded seed is itself the first draw.
    b_seed = 8'hAB; b_seed_load = 1'b1;
    cyc();
    b_seed_load = 1'b0;
    push_b(4'b0001, 8'hAB);
    push_b(4'b0001, 8'h57);
    b_req = 4'b0001;
    cyc(); cyc();
    b_req = '0;
    cyc();
    chk("drain_b", q_b.size(), 0);

    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wait_busy("busy_rr", 8, 1'b0);
    push_a(4'b0001, 8'h58);
    push_a(4'b0010, 8'hB1);
    push_a(4'b0100, 8'h63);
    push_a(4'b1000, 8'hC6);
    push_a(4'b0001, 8'h8C);
    a_req = 4'b1111;
    repeat (5) cyc();
    a_req = '0;
    cyc();
    chk("drain_rr", q_a.size(), 0);

    // Reseed with req held through warm-up: it must be ignored.
    a_seed = 8'hAB; a_seed_load = 1'b1;
    cyc();
    a_seed_load = 1'b0;
    a_req = 4'b0010;
    chk("seed_busy", a_busy, 1);
    wait_busy("busy_seed", 8, 1'b1);
    push_a(4'b0010, 8'hB5);
    cyc();
    a_req = '0;
    cyc();
    chk("drain_seed", q_a.size(), 0);
    m_ptr = 1;

    a_seed = 8'h00; a_seed_load = 1'b1; a_req = 4'b0100;
    cyc();
    a_seed_load = 1'b0; a_req = '0;
    chk("collide_gnt", a_gnt, 0);
    chk("collide_busy", a_busy, 1);
    cyc(); cyc(); cyc();
    a_seed_load = 1'b1;
    cyc();
    a_seed_load = 1'b0;
    wait_busy("busy_restart", 8, 1'b1);

    m_lfsr = 8'h01;
    repeat (8) m_lfsr = step(m_lfsr);
    rec = 1'b1;
    model_draws(4'b0001, 256, 1'b0);
    cyc();
    rec = 1'b0;
    chk("seen_count", seen.size(), 256);
    zeros = 0;
    foreach (seen[i]) if (seen[i] == 8'h00) zeros++;
    chk("zero_draws", zeros, 0);
    if (seen.size() == 256) begin
      chk("zero_seed_first", seen[0], 8'h58);
      chk("period_wrap", seen[255], 8'h58);
    end
    chk("drain_long", q_a.size(), 0);

    // Reset in the middle of a burst.
    model_draws(4'b1111, 3, 1'b1);
    rst = 1'b1;
    cyc();
    chk("midrst_gnt", a_gnt, 0);
    chk("midrst_vld", a_vld, 0);
    chk("midrst_data", a_data, 0);
    chk("midrst_busy", a_busy, 1);
    rst = 1'b0;
    wait_busy("busy_midrst", 8, 1'b1);
    push_a(4'b0001, 8'h58);
    push_a(4'b0010, 8'hB1);
    cyc(); cyc();
    a_req = '0;
    cyc(); cyc();

    done = 1'b1;
    chk("final_q_a", q_a.size(), 0);
    chk("final_q_b", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
